// File: rtl/unix_sec_counter.sv
// Unix seconds counter: free-running prescaler, 64-bit timestamp with
// saturating step adjustments and a handshaked load port.
module unix_sec_counter #(
   parameter int unsigned CLK_FREQ    = 100000000,
   parameter logic [63:0] RESET_STAMP = 64'd1704067200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic        load_valid,
   input  logic [63:0] load_value,
   output logic        load_ready,
   input  logic        adj_up,
   input  logic        adj_down,
   input  logic [1:0]  adj_step,
   output logic [63:0] counter,
   output logic        sec_tick
);

   localparam int unsigned PW      = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(CLK_FREQ - 1);

   typedef enum logic {StAccept, StCommit} state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] presc;
   logic          tick;
   logic          load_acc;
   logic          adj_en;
   logic [64:0]   step65;
   logic [64:0]   base65;
   logic [64:0]   sum65;
   logic [63:0]   counter_d;

   // Tick request and accepted-event qualifiers
   always_comb begin
      tick     = run && (presc == PRE_MAX);
      load_acc = load_valid && load_ready;
      adj_en   = adj_up ^ adj_down;
   end

   // Step size decode
   always_comb begin
      step65 = 65'd1;
      unique case (adj_step)
         2'd0: step65 = 65'd1;
         2'd1: step65 = 65'd60;
         2'd2: step65 = 65'd3600;
         2'd3: step65 = 65'd86400;
      endcase
   end

   // Next counter value: floor-at-zero subtract first, then add step and tick,
   // saturating the final 65-bit sum at all-ones.
   always_comb begin
      base65 = {1'b0, counter};
      if (adj_en && adj_down) begin
         base65 = {1'b0, counter} - step65;
         if (base65[64]) begin
            base65 = '0;
         end
      end
      sum65     = base65 + ((adj_en && adj_up) ? step65 : 65'd0) + {64'd0, tick};
      counter_d = sum65[64] ? '1 : sum65[63:0];
   end

   // Counter, prescaler and tick pulse; an accepted load wins over everything
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         counter  <= RESET_STAMP;
         presc    <= '0;
         sec_tick <= 1'b0;
      end else if (load_acc) begin
         counter  <= load_value;
         presc    <= '0;
         sec_tick <= 1'b0;
      end else begin
         counter  <= counter_d;
         sec_tick <= tick;
         if (tick) begin
            presc <= '0;
         end else if (run) begin
            presc <= presc + PW'(1);
         end
      end
   end

   // Load FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StAccept;
      end else begin
         state_q <= state_d;
      end
   end

   // Load FSM next state: one COMMIT cycle after each acceptance
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StAccept: if (load_valid) state_d = StCommit;
         StCommit: state_d = StAccept;
      endcase
   end

   // Load FSM outputs
   always_comb begin
      load_ready = (state_q == StAccept);
   end

endmodule

// File: tb/tb_unix_sec_counter.sv
// Directed bench for unix_sec_counter with CLK_FREQ=4, RESET_STAMP=100.
module tb_unix_sec_counter;

   localparam logic [63:0] MAXV = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic        load_valid;
   logic [63:0] load_value;
   logic        load_ready;
   logic        adj_up;
   logic        adj_down;
   logic [1:0]  adj_step;
   logic [63:0] counter;
   logic        sec_tick;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        run;
      logic        lv;
      logic [63:0] lval;
      logic        up;
      logic        dn;
      logic [1:0]  step;
      logic [63:0] exp_cnt;
      logic        exp_tick;
      logic        exp_ready;
   } vec_t;

   vec_t vecs[$];

   unix_sec_counter #(
      .CLK_FREQ   (4),
      .RESET_STAMP(64'd100)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .load_valid(load_valid),
      .load_value(load_value),
      .load_ready(load_ready),
      .adj_up    (adj_up),
      .adj_down  (adj_down),
      .adj_step  (adj_step),
      .counter   (counter),
      .sec_tick  (sec_tick)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic r, logic lv, logic [63:0] lval, logic up, logic dn,
                               logic [1:0] st, logic [63:0] c, logic t, logic rd);
      vec_t v;
      v.run = r; v.lv = lv; v.lval = lval; v.up = up; v.dn = dn; v.step = st;
      v.exp_cnt = c; v.exp_tick = t; v.exp_ready = rd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive inputs at the falling edge, then sample just after the rising edge
   task automatic cyc(input logic r, input logic lv, input logic [63:0] lval,
                      input logic up, input logic dn, input logic [1:0] st);
      @(negedge clk);
      run = r; load_valid = lv; load_value = lval;
      adj_up = up; adj_down = dn; adj_step = st;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; load_valid = 1'b0; load_value = '0;
      adj_up = 1'b0; adj_down = 1'b0; adj_step = 2'd0;
      #1;
      chk("reset counter", counter, 64'd100);
      chk("reset load_ready", {63'd0, load_ready}, 64'd1);
      chk("reset sec_tick", {63'd0, sec_tick}, 64'd0);

      // Free run: ticks on every 4th edge
      for (int i = 1; i <= 12; i++) begin
         vecs.push_back(mk(1, 0, 0, 0, 0, 0, 64'd100 + 64'(i / 4), (i % 4) == 0, 1));
      end
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 103, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 103, 0, 1));
      // Pause with prescaler at 2, then two more cycles complete the second
      for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 103, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 103, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 104, 1, 1));
      // Adjustments
      vecs.push_back(mk(1, 0, 0, 1, 0, 1, 164, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 1, 0, 163, 0, 1));
      vecs.push_back(mk(1, 0, 0, 1, 1, 2, 163, 0, 1));
      vecs.push_back(mk(1, 0, 0, 1, 1, 3, 164, 1, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 104, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 0, 2, 3704, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 0, 3, 90104, 0, 1));
      // Load with prescaler mid-count; second request during COMMIT is ignored
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 90104, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 90104, 0, 1));
      vecs.push_back(mk(1, 1, 5000, 0, 0, 0, 5000, 0, 0));
      vecs.push_back(mk(1, 1, 7777, 0, 0, 0, 5000, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5000, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5000, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5001, 1, 1));
      // Saturation at zero
      vecs.push_back(mk(0, 1, 30, 0, 0, 0, 30, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1));

      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         cyc(vecs[i].run, vecs[i].lv, vecs[i].lval, vecs[i].up, vecs[i].dn, vecs[i].step);
         chk($sformatf("vec%0d counter", i), counter, vecs[i].exp_cnt);
         chk($sformatf("vec%0d sec_tick", i), {63'd0, sec_tick}, {63'd0, vecs[i].exp_tick});
         chk($sformatf("vec%0d load_ready", i), {63'd0, load_ready}, {63'd0, vecs[i].exp_ready});
      end

      // Upper saturation: max-2 + 1 s + tick, then tick held at max
      cyc(0, 1, MAXV - 64'd2, 0, 0, 0);
      chk("load max-2", counter, MAXV - 64'd2);
      repeat (3) cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 1, 0, 0);
      chk("up+tick to max", counter, MAXV);
      chk("up+tick sec_tick", {63'd0, sec_tick}, 64'd1);
      cyc(1, 0, 0, 1, 0, 3);
      chk("up at max", counter, MAXV);
      chk("no back-to-back tick", {63'd0, sec_tick}, 64'd0);
      repeat (2) cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      chk("tick at max counter", counter, MAXV);
      chk("tick at max sec_tick", {63'd0, sec_tick}, 64'd1);

      // Load + adj_up + tick in the same cycle: load wins, no pulse
      repeat (3) cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 1, 9000, 1, 0, 1);
      chk("load over tick counter", counter, 64'd9000);
      chk("load over tick sec_tick", {63'd0, sec_tick}, 64'd0);
      chk("load over tick ready", {63'd0, load_ready}, 64'd0);
      repeat (3) cyc(1, 0, 0, 0, 0, 0);
      chk("post-load hold", counter, 64'd9000);
      cyc(1, 0, 0, 0, 0, 0);
      chk("post-load tick", counter, 64'd9001);
      chk("post-load sec_tick", {63'd0, sec_tick}, 64'd1);

      // Reset during COMMIT is asynchronous and discards the load
      cyc(0, 1, 4242, 0, 0, 0);
      chk("commit counter", counter, 64'd4242);
      load_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("async rst counter", counter, 64'd100);
      chk("async rst ready", {63'd0, load_ready}, 64'd1);
      chk("async rst sec_tick", {63'd0, sec_tick}, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) cyc(1, 0, 0, 0, 0, 0);
      chk("first tick not early", counter, 64'd100);
      cyc(1, 0, 0, 0, 0, 0);
      chk("first tick after rst", counter, 64'd101);
      chk("first tick sec_tick", {63'd0, sec_tick}, 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
